// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   mem_size_e  : MemSize encodings carried down from EX.
//   mem_state_e : memory-access FSM state encoding.
//   TIMEOUT_CYC_DEF : default number of wait cycles before a bus error.
//   is_misaligned() : alignment rule shared by the stage and its users.
package mips_pkg;

   localparam int TIMEOUT_CYC_DEF = 16;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_DRAIN = 2'b10
   } mem_state_e;

   // Halves need addr[0]=0; words (and the unused 11 code) need addr[1:0]=00.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (mem_size_e'(size))
         MEM_BYTE: return 1'b0;
         MEM_HALF: return lo[0];
         default:  return lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational little-endian lane formatting for loads and stores.
//   addr_lo  in  2   byte offset within the word
//   size     in  2   byte / half / word
//   sign     in  1   sign-extend loaded value
//   st_data  in  32  store data (low-aligned)
//   rdata    in  32  word returned by data memory
//   wdata    out 32  lane-replicated store data
//   be       out 4   byte enables
//   ld_data  out 32  extracted and extended load value
module mem_align
   import mips_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      case (addr_lo)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (mem_size_e'(size))
         MEM_BYTE: begin
            wdata   = {4{st_data[7:0]}};
            be      = 4'b0001 << addr_lo;
            ld_data = {{24{sign & ld_byte[7]}}, ld_byte};
         end
         MEM_HALF: begin
            wdata   = {2{st_data[15:0]}};
            be      = 4'b0011 << addr_lo;
            ld_data = {{16{sign & ld_half[15]}}, ld_half};
         end
         default: begin
            wdata   = st_data;
            be      = 4'b1111;
            ld_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM stage register, data-memory handshake FSM
// (IDLE/WAIT/DRAIN) with timeout, and MEM/WB result registers.
//   clk, rst_n            clock, synchronous active-low reset
//   EX_* / Flush          upstream instruction fields and squash
//   dmem_*                data-memory request/response
//   Stall_MEM             freezes upstream while an access is outstanding
//   WBData_Mem/Rd_Mem/RegWrite_Mem  forwarding view of the stage register
//   WB_*                  MEM/WB entry
//   AddrErr / BusErr      one-cycle misalignment / timeout pulses
module mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EX_Valid,
   input  logic [31:0] WBData_EX,
   input  logic [31:0] MemData,
   input  logic [4:0]  Rd_Dst,
   input  logic        RegWrite_EX,
   input  logic        MemRead_EX,
   input  logic        MemWrite_EX,
   input  logic [1:0]  MemSize_EX,
   input  logic        MemSign_EX,
   input  logic        Flush,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        Stall_MEM,
   output logic [31:0] WBData_Mem,
   output logic [4:0]  Rd_Mem,
   output logic        RegWrite_Mem,
   output logic        WB_Valid,
   output logic [31:0] WB_Data,
   output logic [4:0]  WB_Rd,
   output logic        WB_RegWrite,
   output logic        AddrErr,
   output logic        BusErr
);

   // Timeout fires in the WAIT cycle whose pre-increment count is TIMEOUT_CYC-1,
   // i.e. the TIMEOUT_CYC-th WAIT cycle.
   localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYC - 1);

   mem_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        flushed_q, flushed_d;
   logic        valid_q, valid_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic        mrd_q, mrd_d;
   logic        mwr_q, mwr_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_rw_q, wb_rw_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_rd_q, wb_rd_d;

   logic        mem_op, misal, stall, fail, kill;
   logic [31:0] ld_data;

   assign mem_op = valid_q & (mrd_q | mwr_q);
   assign misal  = is_misaligned(size_q, addr_q[1:0]);

   mem_align u_align (
      .addr_lo (addr_q[1:0]),
      .size    (size_q),
      .sign    (sign_q),
      .st_data (sdata_q),
      .rdata   (dmem_rdata),
      .wdata   (dmem_wdata),
      .be      (dmem_be),
      .ld_data (ld_data)
   );

   // fail: op completes without a register write (misaligned or timed out).
   // kill: result is squashed (flush now, or flush seen earlier in WAIT).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flushed_d = flushed_q;
      dmem_req  = 1'b0;
      stall     = 1'b0;
      AddrErr   = 1'b0;
      BusErr    = 1'b0;
      fail      = 1'b0;
      kill      = Flush;
      unique case (state_q)
         ST_IDLE: begin
            // A flushed op never starts an access.
            if (mem_op && !Flush) begin
               if (misal) begin
                  AddrErr = 1'b1;
                  fail    = 1'b1;
               end else begin
                  dmem_req = 1'b1;
                  if (!dmem_ack) begin
                     stall     = 1'b1;
                     state_d   = ST_WAIT;
                     cnt_d     = '0;
                     flushed_d = 1'b0;
                  end
               end
            end
         end
         ST_WAIT: begin
            // Request stays up even after a flush; the result is dropped later.
            dmem_req = 1'b1;
            kill     = Flush | flushed_q;
            cnt_d    = cnt_q + 5'd1;
            if (dmem_ack) begin
               state_d   = ST_IDLE;
               flushed_d = 1'b0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               fail      = 1'b1;
               BusErr    = ~kill;
               state_d   = ST_DRAIN;
               flushed_d = 1'b0;
            end else begin
               stall = 1'b1;
               if (Flush) flushed_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            // One cycle to absorb a late ack of the abandoned request.
            stall   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      valid_d    = valid_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      rd_d       = rd_q;
      rw_d       = rw_q;
      mrd_d      = mrd_q;
      mwr_d      = mwr_q;
      size_d     = size_q;
      sign_d     = sign_q;
      wb_valid_d = wb_valid_q;
      wb_rw_d    = wb_rw_q;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      if (!stall) begin
         valid_d    = EX_Valid & ~Flush;
         addr_d     = WBData_EX;
         sdata_d    = MemData;
         rd_d       = Rd_Dst;
         rw_d       = RegWrite_EX;
         mrd_d      = MemRead_EX;
         mwr_d      = MemWrite_EX;
         size_d     = MemSize_EX;
         sign_d     = MemSign_EX;
         wb_valid_d = valid_q & ~kill;
         wb_rw_d    = valid_q & ~kill & rw_q & ~mwr_q & ~fail;
         wb_data_d  = mrd_q ? ld_data : addr_q;
         wb_rd_d    = rd_q;
      end else if (Flush && state_q == ST_DRAIN) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         flushed_q  <= 1'b0;
         valid_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flushed_q  <= flushed_d;
         valid_q    <= valid_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
      end
   end

   // Payload fields are qualified by valid_q and need no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
   end

   assign dmem_we      = mwr_q;
   assign dmem_addr    = {addr_q[31:2], 2'b00};
   assign Stall_MEM    = stall;
   assign WBData_Mem   = addr_q;
   assign Rd_Mem       = rd_q;
   assign RegWrite_Mem = valid_q & rw_q & ~mrd_q;
   assign WB_Valid     = wb_valid_q;
   assign WB_Data      = wb_data_q;
   assign WB_Rd        = wb_rd_q;
   assign WB_RegWrite  = wb_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a transaction-level model.
module tb_mem_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        EX_Valid;
   logic [31:0] WBData_EX, MemData;
   logic [4:0]  Rd_Dst;
   logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemSign_EX, Flush;
   logic [1:0]  MemSize_EX;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        Stall_MEM, RegWrite_Mem, WB_Valid, WB_RegWrite, AddrErr, BusErr;
   logic [31:0] WBData_Mem, WB_Data;
   logic [4:0]  Rd_Mem, WB_Rd;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .EX_Valid(EX_Valid), .WBData_EX(WBData_EX), .MemData(MemData), .Rd_Dst(Rd_Dst),
      .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
      .MemSize_EX(MemSize_EX), .MemSign_EX(MemSign_EX), .Flush(Flush),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .Stall_MEM(Stall_MEM), .WBData_Mem(WBData_Mem), .Rd_Mem(Rd_Mem), .RegWrite_Mem(RegWrite_Mem),
      .WB_Valid(WB_Valid), .WB_Data(WB_Data), .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
      .AddrErr(AddrErr), .BusErr(BusErr)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic load_ex(input bit is_ld, input bit is_st, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] sdata, input bit rw,
                          input logic [4:0] rd);
      EX_Valid    = 1'b1;
      WBData_EX   = addr;
      MemData     = sdata;
      Rd_Dst      = rd;
      RegWrite_EX = rw;
      MemRead_EX  = is_ld;
      MemWrite_EX = is_st;
      MemSize_EX  = size;
      MemSign_EX  = sgn;
   endtask

   // One instruction through the stage. dly: ack arrives dly cycles after the
   // access cycle (>TO means never). fk: cycle index of a one-cycle Flush (-1 none).
   task automatic run_op(input bit is_ld, input bit is_st, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] sdata, input bit rw,
                         input logic [31:0] rdata, input int dly, input int fk);
      logic [4:0]  rd;
      logic [31:0] exp_ld, exp_wd;
      logic [3:0]  exp_be;
      bit          memop, misal, tout, flushed, exp_req, wbv, wbrw;
      int          c, lane;
      rd    = 5'($urandom);
      memop = is_ld | is_st;
      misal = memop && ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00));
      if (!memop || misal || fk == 0) c = 0;
      else if (dly <= TO) c = dly;
      else c = TO;
      tout    = memop && !misal && fk != 0 && dly > TO;
      flushed = fk >= 0 && fk <= c;
      exp_req = memop && !misal && fk != 0;
      lane    = int'(addr[1:0]);
      case (size)
         2'b00: begin
            exp_ld = (rdata >> (8 * lane)) & 32'hFF;
            if (sgn && exp_ld[7]) exp_ld = exp_ld | 32'hFFFF_FF00;
            exp_be = 4'(1 << lane);
            exp_wd = (sdata & 32'hFF) * 32'h0101_0101;
         end
         2'b01: begin
            exp_ld = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
            if (sgn && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF_0000;
            exp_be = 4'(3 << lane);
            exp_wd = (sdata & 32'hFFFF) * 32'h0001_0001;
         end
         default: begin
            exp_ld = rdata;
            exp_be = 4'hF;
            exp_wd = sdata;
         end
      endcase

      @(negedge clk);
      load_ex(is_ld, is_st, size, sgn, addr, sdata, rw, rd);
      Flush    = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      EX_Valid  = 1'b0;
      WBData_EX = $urandom;
      MemData   = $urandom;
      for (int k = 0; k <= c; k++) begin
         dmem_ack   = memop && (k == dly);
         dmem_rdata = (k == dly) ? rdata : $urandom;
         Flush      = (k == fk);
         #1;
         check_eq("req", 32'(dmem_req), 32'(exp_req));
         check_eq("stall", 32'(Stall_MEM), 32'(k < c));
         check_eq("addr_err", 32'(AddrErr), 32'(k == 0 && misal && fk != 0));
         check_eq("bus_err", 32'(BusErr), 32'(tout && k == c && !flushed));
         if (exp_req) begin
            check_eq("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check_eq("dmem_we", 32'(dmem_we), 32'(is_st));
            if (is_st) begin
               check_eq("dmem_be", 32'(dmem_be), 32'(exp_be));
               check_eq("dmem_wdata", dmem_wdata, exp_wd);
            end
         end
         if (k == 0) begin
            check_eq("fwd_data", WBData_Mem, addr);
            check_eq("fwd_rd", 32'(Rd_Mem), 32'(rd));
            check_eq("fwd_rw", 32'(RegWrite_Mem), 32'(rw && !is_ld));
         end
         @(negedge clk);
      end
      Flush    = 1'b0;
      dmem_ack = 1'b0;
      #1;
      wbv  = !flushed;
      wbrw = wbv && rw && !is_st && !misal && !tout;
      check_eq("wb_valid", 32'(WB_Valid), 32'(wbv));
      check_eq("wb_regwrite", 32'(WB_RegWrite), 32'(wbrw));
      if (wbrw) check_eq("wb_data", WB_Data, is_ld ? exp_ld : addr);
      if (wbv) check_eq("wb_rd", 32'(WB_Rd), 32'(rd));
      if (tout) begin
         check_eq("drain_stall", 32'(Stall_MEM), 32'd1);
         check_eq("drain_req", 32'(dmem_req), 32'd0);
         @(negedge clk);
         #1;
         check_eq("post_drain_stall", 32'(Stall_MEM), 32'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          typ, dly, fk;
      bit          rw;

      rst_n = 1'b0;
      load_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 5'd3);
      Flush      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_wb_valid", 32'(WB_Valid), 32'd0);
      check_eq("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
      check_eq("rst_wb_data", WB_Data, 32'd0);
      check_eq("rst_wb_rd", 32'(WB_Rd), 32'd0);
      check_eq("rst_req", 32'(dmem_req), 32'd0);
      check_eq("rst_stall", 32'(Stall_MEM), 32'd0);
      check_eq("rst_addr_err", 32'(AddrErr), 32'd0);
      check_eq("rst_bus_err", 32'(BusErr), 32'd0);
      EX_Valid = 1'b0;
      rst_n    = 1'b1;

      // Directed cases
      run_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h80FF1234, 0, -1);
      run_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80FF1234, 0, -1);
      run_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 1, 32'h80FF1234, 0, -1);
      run_op(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 0, 32'h0, 3, -1);
      run_op(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h12345678, 0, -1);
      run_op(1, 0, 2'b10, 0, 32'h200, 32'h0, 1, 32'h0, 99, -1);
      run_op(1, 0, 2'b10, 0, 32'h204, 32'h0, 1, 32'hCAFEF00D, 6, 3);
      run_op(1, 0, 2'b01, 1, 32'h206, 32'h0, 1, 32'h8001_0000, 2, 2);
      run_op(1, 0, 2'b10, 0, 32'h208, 32'h0, 1, 32'h0, 99, 5);
      run_op(0, 0, 2'b10, 0, 32'h5555, 32'h0, 1, 32'h0, 0, 0);
      run_op(0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 1, 32'h0, 0, -1);
      run_op(1, 0, 2'b10, 0, 32'h300, 32'h0, 1, 32'h0BAD_BEEF, TO, -1);

      // Abandon an outstanding access with reset; a late ack must be ignored
      @(negedge clk);
      load_ex(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 5'd9);
      @(negedge clk);
      EX_Valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check_eq("wait_rst_req", 32'(dmem_req), 32'd0);
      check_eq("wait_rst_stall", 32'(Stall_MEM), 32'd0);
      rst_n    = 1'b1;
      dmem_ack = 1'b1;
      #1;
      check_eq("late_ack_req", 32'(dmem_req), 32'd0);
      check_eq("late_ack_stall", 32'(Stall_MEM), 32'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      check_eq("late_ack_wb_valid", 32'(WB_Valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         typ = $urandom_range(0, 2);
         sz  = 2'($urandom_range(0, 2));
         a   = $urandom;
         if ($urandom_range(0, 3) != 0)
            a = a & ~((sz == 2'b01) ? 32'h1 : (sz == 2'b10) ? 32'h3 : 32'h0);
         dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TO + 1, TO + 4) : $urandom_range(0, 4);
         fk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
         rw  = (typ == 1) ? 1'b1 : (typ == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         run_op(typ == 1, typ == 2, sz, 1'($urandom_range(0, 1)), a, $urandom, rw, $urandom, dly, fk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: the maximum number of cycles the stage waits for dmem_ack before raising BusErr.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset; state the ports exactly so:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
REQ-003 Upstream (EX) ports:
- EX_Valid  in  1  EX result valid.
- WBData_EX  in  32  ALU/shift result; effective address for memory ops.
- MemData  in  32  forwarded store data.
- Rd_Dst  in  5  destination register.
- RegWrite_EX  in  1  instruction writes a register.
- MemRead_EX  in  1  load.
- MemWrite_EX  in  1  store.
- MemSize_EX  in  2  00 byte, 01 half, 10 word.
- MemSign_EX  in  1  sign-extend loads.
- Flush  in  1  squash the stage contents.
REQ-004 Data memory ports:
- dmem_req  out  1  request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address, [1:0]=00.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  completion.
- dmem_rdata  in  32  read word.
REQ-005 Downstream (WB) and hazard ports:
- Stall_MEM  out  1  freeze upstream.
- WBData_Mem  out  32  forwarding value (stage-register result).
- Rd_Mem  out  5  stage-register destination.
- RegWrite_Mem  out  1  stage-register write-enable, gated by valid.
- WB_Valid  out  1  MEM/WB entry valid.
- WB_Data  out  32  value to write back.
- WB_Rd  out  5  write-back destination.
- WB_RegWrite  out  1  write-back enable.
- AddrErr  out  1  one-cycle misalignment pulse.
- BusErr  out  1  one-cycle timeout pulse.

Function
REQ-006 The stage register SHALL load all EX inputs on a rising edge when Stall_MEM=0; it SHALL hold its contents when Stall_MEM=1.
REQ-007 The FSM SHALL have states IDLE, WAIT and DRAIN; the access cycle is the first cycle a valid memory op sits in the stage register with state IDLE.
REQ-008 In IDLE, for a valid aligned memory op, dmem_req SHALL be 1 combinationally; if dmem_ack=1 in the same cycle the op completes, otherwise the FSM SHALL go to WAIT.
REQ-009 In WAIT, dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_be SHALL be held stable until dmem_ack; on ack the FSM SHALL return to IDLE.
REQ-010 Stall_MEM SHALL be 1 whenever a memory op is outstanding and dmem_ack=0 this cycle; a non-memory op SHALL never stall.
REQ-011 The MEM/WB registers SHALL update at the end of every non-stalled cycle.
- Non-memory op: WB_Data=WBData_EX.
- Load: WB_Data=the formatted dmem_rdata.
- Store: WB_RegWrite=0.
- Latency: one cycle with zero-wait memory.
REQ-012 Load formatting SHALL be little-endian with lane = addr[1:0].
- Byte: lane addr[1:0].
- Half: bytes addr[1]*2 and addr[1]*2+1.
- Sign-extend when MemSign_EX=1, otherwise zero-extend.
REQ-013 Store formatting:
- Byte: data[7:0] replicated to 4 lanes, be=0001<<addr[1:0].
- Half: data[15:0] replicated to both halves, be=0011<<addr[1:0].
- Word: be=1111.
REQ-014 Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL issue no request and SHALL pulse AddrErr for one cycle. The resulting WB entry SHALL have WB_RegWrite=0 and WB_Valid=1.
REQ-015 A 5-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
- On reaching TIMEOUT_CYC, BusErr SHALL pulse once and the op SHALL complete with WB_RegWrite=0.
- The FSM SHALL then go to DRAIN, which holds Stall_MEM=1 and keeps dmem_req=0 until dmem_ack is seen or one further cycle elapses, then returns to IDLE.
REQ-016 Flush in IDLE SHALL invalidate the stage register at the next edge.
REQ-017 Flush in WAIT SHALL keep the request held until ack; the result SHALL then be discarded (WB_Valid=0) and no error SHALL be raised.
REQ-018 Flush and ack in the same cycle SHALL discard the result.
REQ-019 WBData_Mem, Rd_Mem and RegWrite_Mem SHALL reflect the stage register combinationally; RegWrite_Mem SHALL be 0 for loads, because load data is not yet forwardable.

Reset
REQ-020 Under rst_n=0 at a clock edge:
- FSM=IDLE, stage valid=0, counter=0.
- WB_Valid=0, WB_RegWrite=0, WB_Data=0, WB_Rd=0.
- dmem_req=0, Stall_MEM=0, AddrErr=0, BusErr=0.
REQ-021 Reset during WAIT SHALL abandon the access immediately; a late dmem_ack after reset SHALL be ignored.

Structure
REQ-022 The MemSize encodings, the FSM state encoding and the TIMEOUT_CYC default SHALL live in a shared package, mips_pkg.
REQ-023 Load/store lane formatting SHALL be one combinational sub-module, mem_align.

Verification
REQ-024 Word load, addr 0x100, rdata 0x80FF1234, ack same cycle -> WB_Data=0x80FF1234 next cycle, Stall_MEM never 1.
REQ-025 Signed byte load, addr 0x103, rdata 0x80FF1234 -> WB_Data=0xFFFFFF80; the unsigned variant -> 0x00000080.
REQ-026 Half store, addr 0x102, MemData 0x0000ABCD, ack after 3 cycles -> be=1100, wdata=0xABCDABCD held stable, Stall_MEM=1 for exactly 3 cycles.
REQ-027 Word load at 0x101 -> no dmem_req, AddrErr pulse, WB_RegWrite=0.
REQ-028 No ack for 16 cycles -> BusErr pulse in WAIT cycle 16, then DRAIN, then IDLE; Flush asserted mid-WAIT with a later ack -> WB_Valid=0.
